// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
// Holds the FSM state encoding, parity-mode values and a counter-width helper.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam int PAR_MODE_EVEN = 0;
  localparam int PAR_MODE_ODD  = 1;

  // Bits needed to count 0..max_count-1, never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period prescaler: bit_tick is high in the last clock of each CLK_DIV-cycle bit.
// restart realigns the count so the next cycle begins a fresh bit period.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int             CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == LAST);

  always_comb begin
    if (restart || bit_tick) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: shifts a WIDTH-bit word out with optional parity,
// then a one-bit-period gap; a one-entry holding register queues the next word.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int CLK_DIV    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             tx_valid,
  output logic             tx_data,
  output logic             done
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic          ODD      = (PARITY_ODD == PAR_MODE_ODD);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             par_q, par_d;
  logic             done_q, done_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             restart, bit_tick, accept, gap_end, line_bit;

  serial_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

  assign ready    = !hold_full_q;
  assign accept   = start && ready;
  assign gap_end  = (state_q == ST_GAP) && bit_tick;
  assign line_bit = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    restart     = 1'b0;

    // While a frame is running, an accepted word waits in the holding register.
    if (accept && (state_q != ST_IDLE) && !gap_end) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d   = data;
          par_d     = (^data) ^ ODD;
          bit_cnt_d = '0;
          restart   = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (bit_tick) begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            par_d       = (^hold_q) ^ ODD;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
            restart     = 1'b1;
            state_d     = ST_SHIFT;
          end else if (accept) begin
            // Request arriving in the final gap cycle goes straight to the shifter.
            shift_d   = data;
            par_d     = (^data) ^ ODD;
            bit_cnt_d = '0;
            restart   = 1'b1;
            state_d   = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    done_d = (state_d == ST_GAP) && (state_q != ST_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      done_q      <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      done_q      <= done_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign tx_valid = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
  assign tx_data  = tx_valid && ((state_q == ST_PARITY) ? par_q : line_bit);
  assign done     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: directed tables/sequences on several
// parameter sets, then random traffic against a frame-timing reference model.
module tb_serial_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  start;
  logic [31:0] data [5];
  logic [4:0]  ready, tx_valid, tx_data, done;

  always #5 clk = ~clk;

  // Instance configurations: width, msb_first, parity_en, parity_odd, clk_div.
  int cw  [5] = '{4, 4, 4, 1, 32};
  int cmsb[5] = '{1, 0, 1, 1, 0};
  int cpen[5] = '{0, 1, 0, 1, 1};
  int codd[5] = '{0, 0, 0, 1, 0};
  int cdiv[5] = '{1, 1, 3, 2, 5};

  serial_frame_tx #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0), .CLK_DIV(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .data(data[0][3:0]),
    .ready(ready[0]), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .done(done[0]));
  serial_frame_tx #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0), .CLK_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .data(data[1][3:0]),
    .ready(ready[1]), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .done(done[1]));
  serial_frame_tx #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0), .CLK_DIV(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .data(data[2][3:0]),
    .ready(ready[2]), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]), .done(done[2]));
  serial_frame_tx #(.WIDTH(1), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1), .CLK_DIV(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .data(data[3][0:0]),
    .ready(ready[3]), .tx_valid(tx_valid[3]), .tx_data(tx_data[3]), .done(done[3]));
  serial_frame_tx #(.WIDTH(32), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0), .CLK_DIV(5)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start[4]), .data(data[4]),
    .ready(ready[4]), .tx_valid(tx_valid[4]), .tx_data(tx_data[4]), .done(done[4]));

  int nchecks = 0;
  int nerr    = 0;

  task automatic check(input string name, input logic act, input logic exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed per-cycle vectors for the default instance.
  typedef struct {
    logic       start;
    logic [3:0] data;
    logic       ready;
    logic       valid;
    logic       txd;
    logic       done;
  } vec_t;
  vec_t vecs [19];

  // Reference model: a frame accepted/started at cycle fs drives bits in
  // cycles fs+1 .. fs+nbits*div, then a gap of div cycles with done on its first.
  typedef struct {
    bit          active;
    longint      fs;
    logic [31:0] word;
    bit          pend;
    logic [31:0] pword;
  } mdl_t;
  mdl_t mdl [5];

  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  task automatic model_exp(input int i, input longint t,
                           output logic ev, output logic ed, output logic edn, output logic er);
    int nb, off, k, idx;
    ev = 1'b0; ed = 1'b0; edn = 1'b0;
    er = !mdl[i].pend;
    if (mdl[i].active) begin
      nb  = cw[i] + cpen[i];
      off = int'(t - mdl[i].fs - 1);
      if (off < nb * cdiv[i]) begin
        ev = 1'b1;
        k  = off / cdiv[i];
        if (k < cw[i]) begin
          idx = (cmsb[i] != 0) ? (cw[i] - 1 - k) : k;
          ed  = mdl[i].word[idx];
        end else begin
          ed = (^(mdl[i].word & wmask(cw[i]))) ^ (codd[i] != 0);
        end
      end else if (off == nb * cdiv[i]) begin
        edn = 1'b1;
      end
    end
  endtask

  task automatic model_step(input int i, input longint t, input logic st, input logic [31:0] d);
    bit acc, last;
    int nb, off;
    acc = st && !mdl[i].pend;
    if (!mdl[i].active) begin
      if (acc) begin
        mdl[i].active = 1'b1;
        mdl[i].fs     = t;
        mdl[i].word   = d & wmask(cw[i]);
      end
    end else begin
      nb   = cw[i] + cpen[i];
      off  = int'(t - mdl[i].fs - 1);
      last = (off == (nb + 1) * cdiv[i] - 1);
      if (last) begin
        if (mdl[i].pend) begin
          mdl[i].fs   = t;
          mdl[i].word = mdl[i].pword;
          mdl[i].pend = 1'b0;
        end else if (acc) begin
          mdl[i].fs   = t;
          mdl[i].word = d & wmask(cw[i]);
        end else begin
          mdl[i].active = 1'b0;
        end
      end else if (acc) begin
        mdl[i].pend  = 1'b1;
        mdl[i].pword = d & wmask(cw[i]);
      end
    end
  endtask

  initial begin
    logic       b_v  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       b_d  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       b_dn [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] pat;
    logic       ev, ed, edn, er;

    // {start, data, ready, valid, txd, done}
    vecs[0]  = '{1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = '0;
    for (int i = 0; i < 5; i++) data[i] = '0;

    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("reset u%0d ready", i), ready[i], 1'b1);
      check($sformatf("reset u%0d tx_valid", i), tx_valid[i], 1'b0);
      check($sformatf("reset u%0d tx_data", i), tx_data[i], 1'b0);
      check($sformatf("reset u%0d done", i), done[i], 1'b0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single frame, then back-to-back queueing with an ignored third request.
    for (int r = 0; r < 19; r++) begin
      @(negedge clk);
      check($sformatf("table row %0d ready", r), ready[0], vecs[r].ready);
      check($sformatf("table row %0d tx_valid", r), tx_valid[0], vecs[r].valid);
      check($sformatf("table row %0d tx_data", r), tx_data[0], vecs[r].txd);
      check($sformatf("table row %0d done", r), done[0], vecs[r].done);
      start[0] = vecs[r].start;
      data[0]  = {28'd0, vecs[r].data};
    end
    start[0] = 1'b0;

    // LSB first with even parity: 0111 -> 1,1,1,0, parity 1.
    @(negedge clk);
    start[1] = 1'b1;
    data[1]  = 32'h7;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start[1] = 1'b0;
      data[1]  = $urandom;
      check($sformatf("lsb/parity cycle %0d tx_valid", c), tx_valid[1], b_v[c-1]);
      check($sformatf("lsb/parity cycle %0d tx_data", c), tx_data[1], b_d[c-1]);
      check($sformatf("lsb/parity cycle %0d done", c), done[1], b_dn[c-1]);
    end

    // CLK_DIV=3: each bit of 1001 held 3 cycles, gap of 3, done at cycle 13.
    pat = 4'b1001;
    @(negedge clk);
    start[2] = 1'b1;
    data[2]  = {28'd0, pat};
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start[2] = 1'b0;
      data[2]  = $urandom;
      check($sformatf("div3 cycle %0d tx_valid", c), tx_valid[2], c <= 12);
      check($sformatf("div3 cycle %0d tx_data", c), tx_data[2], (c <= 12) ? pat[3 - (c - 1) / 3] : 1'b0);
      check($sformatf("div3 cycle %0d done", c), done[2], c == 13);
      check($sformatf("div3 cycle %0d ready", c), ready[2], 1'b1);
    end

    // Reset mid-frame with a queued word; the queued word must not survive.
    @(negedge clk);
    start[0] = 1'b1;
    data[0]  = 32'hF;
    @(negedge clk);
    check("midreset pre tx_valid", tx_valid[0], 1'b1);
    check("midreset pre tx_data", tx_data[0], 1'b1);
    start[0] = 1'b1;
    data[0]  = 32'h3;
    @(negedge clk);
    start[0] = 1'b0;
    check("midreset queued ready", ready[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset tx_valid", tx_valid[0], 1'b0);
    check("midreset tx_data", tx_data[0], 1'b0);
    check("midreset done", done[0], 1'b0);
    check("midreset ready", ready[0], 1'b1);
    @(negedge clk);
    check("midreset held done", done[0], 1'b0);
    check("midreset held tx_valid", tx_valid[0], 1'b0);
    rst_n = 1'b1;
    pat = 4'h6;
    @(negedge clk);
    start[0] = 1'b1;
    data[0]  = {28'd0, pat};
    for (int c = 5; c <= 11; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      data[0]  = $urandom;
      check($sformatf("postreset cycle %0d tx_valid", c), tx_valid[0], (c >= 5) && (c <= 8));
      check($sformatf("postreset cycle %0d tx_data", c), tx_data[0],
            ((c >= 5) && (c <= 8)) ? pat[3 - (c - 5)] : 1'b0);
      check($sformatf("postreset cycle %0d done", c), done[0], c == 9);
    end

    // Random traffic on every instance, scored against the reference model.
    for (int i = 0; i < 5; i++) begin
      mdl[i].active = 1'b0;
      mdl[i].fs     = 0;
      mdl[i].word   = '0;
      mdl[i].pend   = 1'b0;
      mdl[i].pword  = '0;
    end
    @(negedge clk);
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        model_exp(i, longint'(t), ev, ed, edn, er);
        check($sformatf("rand u%0d t%0d tx_valid", i, t), tx_valid[i], ev);
        check($sformatf("rand u%0d t%0d tx_data", i, t), tx_data[i], ed);
        check($sformatf("rand u%0d t%0d done", i, t), done[i], edn);
        check($sformatf("rand u%0d t%0d ready", i, t), ready[i], er);
        start[i] = ($urandom_range(0, 2) == 0);
        data[i]  = $urandom;
        model_step(i, longint'(t), start[i], data[i]);
      end
    end
    start = '0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter WIDTH, default 4, payload bits per frame; legal range 1..32.
REQ-002 Parameter MSB_FIRST, default 1, 1 = MSB first, 0 = LSB first.
REQ-003 Parameter PARITY_EN, default 0, 1 = append one parity bit after the payload.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter CLK_DIV, default 1, clock cycles per serial bit; legal range 1..255.
REQ-006 clk  input  1  single system clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  transmit request; accepted only in a cycle where ready=1.
REQ-009 data  input  WIDTH  payload; sampled only in the accept cycle.
REQ-010 ready  output  1  1 = the one-entry holding register is empty and a request can be accepted.
REQ-011 tx_valid  output  1  frame-active strobe; 1 for every payload and parity bit period.
REQ-012 tx_data  output  1  serial line; 0 whenever tx_valid=0.
REQ-013 done  output  1  one-cycle pulse marking the end of each completed frame.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT, PARITY and GAP.
REQ-015 A request accepted in IDLE at cycle N SHALL load the shift register, and tx_valid=1 with the first bit SHALL appear from cycle N+1.
REQ-016 Each bit SHALL be held for exactly CLK_DIV cycles, timed by a bit-tick prescaler that restarts at the beginning of each frame.
REQ-017 Payload order SHALL follow MSB_FIRST; after WIDTH bits, the FSM SHALL go to PARITY if PARITY_EN=1, otherwise to GAP.
REQ-018 The parity bit SHALL equal the XOR of the accepted payload, inverted when PARITY_ODD=1.
REQ-019 GAP SHALL last one bit period with tx_valid=0 and tx_data=0; done=1 SHALL be asserted in the first GAP cycle only.
REQ-020 At the end of GAP, a full holding register SHALL transfer to the shift register, the FSM SHALL enter SHIFT, and ready SHALL return to 1 in that same cycle; otherwise the FSM SHALL enter IDLE.
REQ-021 start with ready=1 while in SHIFT, PARITY or GAP SHALL load the holding register; ready SHALL be 0 from the next cycle.
REQ-022 start while ready=0 SHALL be ignored without error, and the queued word SHALL be unaffected.
REQ-023 A request accepted in IDLE SHALL bypass the holding register, so ready stays 1.
REQ-024 Changes on data after acceptance SHALL not affect the frame in flight or the queued word.
REQ-025 Bit counter and prescaler widths SHALL be $clog2-sized from WIDTH and CLK_DIV; no counter SHALL wrap within a frame.

Reset
REQ-026 rst_n=0 SHALL immediately force FSM=IDLE, tx_valid=0, tx_data=0, done=0, ready=1, and clear the shift register, holding register and counters.
REQ-027 Reset mid-frame SHALL abort the frame without a done pulse; the first accept after release SHALL transmit a clean full frame.

Structure
REQ-028 A shared package serial_pkg SHALL hold the FSM state enum and the parity-mode constants.
REQ-029 The prescaler SHALL be a sub-module serial_bit_timer (inputs clk, rst_n, restart; output bit_tick), parametrised by CLK_DIV.

Verification
REQ-030 Defaults, data=4'b1011 accepted at cycle 0 -> tx_valid=1 at cycles 1-4, tx_data 1,0,1,1; done=1 and tx_valid=0 at cycle 5.
REQ-031 MSB_FIRST=0, PARITY_EN=1, even parity, data=4'b0111 -> bits 1,1,1,0 then parity 1; tx_valid high for 5 cycles.
REQ-032 Defaults, 4'hA at cycle 0, 4'h5 at cycle 2, 4'hF at cycle 3 -> ready=0 at cycles 3-5, 4'hF ignored, 4'h5 first bit at cycle 6, two done pulses.
REQ-033 CLK_DIV=3, data=4'b1001 -> each bit held 3 cycles, tx_valid high for 12 cycles, gap of 3 cycles, done at cycle 13.
REQ-034 rst_n low at cycle 2 mid-frame -> all outputs 0 in that cycle, no done; after release, 4'h6 transmits 0,1,1,0.
REQ-035 WIDTH=1 and WIDTH=32 with random data and random CLK_DIV -> a scoreboard matches every bit and every parity bit.
